// File: rtl/nbit_pc_stack.sv
`default_nettype none
// ============================================================================
//  Module   : nbit_pc_stack
//  Purpose  : Parametrised program counter with stride increment, relative
//             branch, and a LIFO return-address stack for call/return.
//  Revision : 1.0  initial release
// ============================================================================
module nbit_pc_stack #(
   parameter  int WIDTH = 8,
   parameter  int INC   = 2,
   parameter  int DEPTH = 4,
   localparam int SP_W  = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [2:0]       ctrl,
   input  logic [WIDTH-1:0] pc_in,
   output logic [WIDTH-1:0] pc_out,
   output logic [SP_W-1:0]  sp,
   output logic             full,
   output logic             empty,
   output logic             err
);

   // Operation encodings driven by the controller
   localparam logic [2:0] OP_HOLD   = 3'b000;
   localparam logic [2:0] OP_LOAD   = 3'b001;
   localparam logic [2:0] OP_INC1   = 3'b010;
   localparam logic [2:0] OP_INCN   = 3'b011;
   localparam logic [2:0] OP_CALL   = 3'b100;
   localparam logic [2:0] OP_RET    = 3'b101;
   localparam logic [2:0] OP_BRANCH = 3'b110;

   // Stride and unit step already reduced modulo 2^WIDTH
   localparam logic [WIDTH-1:0] C_ONE   = WIDTH'(1);
   localparam logic [WIDTH-1:0] C_INC   = WIDTH'(INC);
   localparam logic [SP_W-1:0]  C_SP1   = SP_W'(1);
   localparam logic [SP_W-1:0]  C_DEPTH = SP_W'(DEPTH);

   logic [WIDTH-1:0] pc_q,  pc_d;
   logic [SP_W-1:0]  sp_q,  sp_d;
   logic             err_q, err_d;
   logic             push;
   logic [WIDTH-1:0] ret_addr;
   logic [WIDTH-1:0] top;
   logic [WIDTH-1:0] stack_q [DEPTH];

   assign full     = (sp_q == C_DEPTH);
   assign empty    = (sp_q == '0);
   assign ret_addr = pc_q + C_ONE;

   // Select the most recently pushed entry (index sp-1); value is don't-care when empty
   always_comb begin
      top = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (sp_q == SP_W'(i + 1)) begin
            top = stack_q[i];
         end
      end
   end

   // Next-state decode of the control code; rejected call/return only raises err
   always_comb begin
      pc_d  = pc_q;
      sp_d  = sp_q;
      err_d = 1'b0;
      push  = 1'b0;
      case (ctrl)
         OP_HOLD: ;
         OP_LOAD: pc_d = pc_in;
         OP_INC1: pc_d = pc_q + C_ONE;
         OP_INCN: pc_d = pc_q + C_INC;
         OP_CALL: begin
            if (full) begin
               err_d = 1'b1;
            end else begin
               push = ~clr;
               sp_d = sp_q + C_SP1;
               pc_d = pc_in;
            end
         end
         OP_RET: begin
            if (empty) begin
               err_d = 1'b1;
            end else begin
               sp_d = sp_q - C_SP1;
               pc_d = top;
            end
         end
         // A WIDTH-bit add already equals adding the sign-extended offset mod 2^WIDTH
         OP_BRANCH: pc_d = pc_q + pc_in;
         default: ;
      endcase
   end

   // PC, stack pointer and error pulse; clr clears them without a clock
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         pc_q  <= '0;
         sp_q  <= '0;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         sp_q  <= sp_d;
         err_q <= err_d;
      end
   end

   // Stack storage is not reset; entries at or above sp are never read
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (push && (sp_q == SP_W'(i))) begin
            stack_q[i] <= ret_addr;
         end
      end
   end

   assign pc_out = pc_q;
   assign sp     = sp_q;
   assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_nbit_pc_stack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nbit_pc_stack
//  Purpose  : Self-checking bench for nbit_pc_stack (WIDTH=4, INC=2, DEPTH=2)
//  Revision : 1.0  initial release
// ============================================================================
module tb_nbit_pc_stack;

   localparam int WIDTH = 4;
   localparam int INC   = 2;
   localparam int DEPTH = 2;
   localparam int SP_W  = 2;

   typedef struct packed {
      logic [WIDTH-1:0] pc;
      logic [SP_W-1:0]  sp;
      logic             err;
      logic             full;
      logic             empty;
   } exp_t;

   logic             clk = 1'b0;
   logic             clr;
   logic [2:0]       ctrl;
   logic [WIDTH-1:0] pc_in;
   logic [WIDTH-1:0] pc_out;
   logic [SP_W-1:0]  sp;
   logic             full;
   logic             empty;
   logic             err;

   int checks = 0;
   int errors = 0;

   exp_t sb_q[$];

   // Behavioural reference state
   logic [WIDTH-1:0] m_pc;
   int               m_sp;
   logic [WIDTH-1:0] m_stack [DEPTH];

   nbit_pc_stack #(.WIDTH(WIDTH), .INC(INC), .DEPTH(DEPTH)) dut (
      .clk    (clk),
      .clr    (clr),
      .ctrl   (ctrl),
      .pc_in  (pc_in),
      .pc_out (pc_out),
      .sp     (sp),
      .full   (full),
      .empty  (empty),
      .err    (err)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag, input exp_t e);
      cmp({tag, ".pc"},    8'(pc_out), 8'(e.pc));
      cmp({tag, ".sp"},    8'(sp),     8'(e.sp));
      cmp({tag, ".err"},   8'(err),    8'(e.err));
      cmp({tag, ".full"},  8'(full),   8'(e.full));
      cmp({tag, ".empty"}, 8'(empty),  8'(e.empty));
   endtask

   function automatic exp_t model_state(input logic e_err);
      exp_t e;
      e.pc    = m_pc;
      e.sp    = SP_W'(m_sp);
      e.err   = e_err;
      e.full  = (m_sp == DEPTH);
      e.empty = (m_sp == 0);
      return e;
   endfunction

   // Advance the reference model by one op and return its expected outputs
   function automatic exp_t model_step(input logic [2:0] c, input logic [WIDTH-1:0] d);
      logic e_err;
      e_err = 1'b0;
      case (c)
         3'd1: m_pc = d;
         3'd2: m_pc = (m_pc + 1) % 16;
         3'd3: m_pc = (m_pc + INC) % 16;
         3'd4: begin
            if (m_sp == DEPTH) e_err = 1'b1;
            else begin
               m_stack[m_sp] = (m_pc + 1) % 16;
               m_sp++;
               m_pc = d;
            end
         end
         3'd5: begin
            if (m_sp == 0) e_err = 1'b1;
            else begin
               m_sp--;
               m_pc = m_stack[m_sp];
            end
         end
         3'd6: m_pc = WIDTH'($signed({1'b0, m_pc}) + $signed({d[3], d}));
         default: ;
      endcase
      return model_state(e_err);
   endfunction

   // Drive one op on negedge, queue the prediction, compare after the posedge
   task automatic step(input string tag, input logic [2:0] c, input logic [WIDTH-1:0] d);
      exp_t e;
      @(negedge clk);
      ctrl  = c;
      pc_in = d;
      sb_q.push_back(model_step(c, d));
      @(posedge clk);
      #1;
      checks++;
      assert (sb_q.size() != 0) else begin
         errors++;
         $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
      end
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check_all(tag, e);
      end
   endtask

   // Assert clr between edges, confirm immediate reset, release after next edge
   task automatic do_clr(input string tag);
      @(negedge clk);
      ctrl = 3'd0;
      clr  = 1'b1;
      #1;
      m_pc = '0;
      m_sp = 0;
      check_all({tag, ".async"}, model_state(1'b0));
      cmp({tag, ".async_pc0"}, 8'(pc_out), 8'h00);
      @(posedge clk);
      #1;
      check_all({tag, ".held"}, model_state(1'b0));
      clr = 1'b0;
   endtask

   initial begin
      clr   = 1'b1;
      ctrl  = 3'd0;
      pc_in = '0;
      m_pc  = '0;
      m_sp  = 0;
      #1;
      check_all("reset", model_state(1'b0));
      @(posedge clk);
      #2;
      clr = 1'b0;

      // Reset and hold
      step("ld9", 3'd1, 4'h9);
      step("call5", 3'd4, 4'h5);
      do_clr("clr1");
      step("hold1", 3'd0, 4'h0);
      step("hold2", 3'd0, 4'h0);
      step("hold3", 3'd0, 4'h0);
      cmp("hold_pc0", 8'(pc_out), 8'h00);

      // Increment wrap
      step("ldE", 3'd1, 4'hE);
      step("inc1a", 3'd2, 4'h0);
      cmp("inc1a_pcF", 8'(pc_out), 8'h0F);
      step("inc1b", 3'd2, 4'h0);
      cmp("inc1b_pc0", 8'(pc_out), 8'h00);
      step("incna", 3'd3, 4'h0);
      cmp("incna_pc2", 8'(pc_out), 8'h02);
      step("incnb", 3'd3, 4'h0);
      cmp("incnb_pc4", 8'(pc_out), 8'h04);
      step("ldF", 3'd1, 4'hF);
      step("incnF", 3'd3, 4'h0);
      cmp("incnF_pc1", 8'(pc_out), 8'h01);

      // Branch with signed offsets
      step("ld3", 3'd1, 4'h3);
      step("brm2", 3'd6, 4'hE);
      cmp("brm2_pc1", 8'(pc_out), 8'h01);
      step("brp3", 3'd6, 4'h3);
      cmp("brp3_pc4", 8'(pc_out), 8'h04);
      step("brm4", 3'd6, 4'hC);
      cmp("brm4_pc0", 8'(pc_out), 8'h00);

      // Call/return nesting
      step("ld5", 3'd1, 4'h5);
      step("call8", 3'd4, 4'h8);
      step("callC", 3'd4, 4'hC);
      cmp("callC_pcC", 8'(pc_out), 8'h0C);
      cmp("callC_full", 8'(full), 8'h01);
      step("ret1", 3'd5, 4'h0);
      cmp("ret1_pc9", 8'(pc_out), 8'h09);
      step("ret2", 3'd5, 4'h0);
      cmp("ret2_pc6", 8'(pc_out), 8'h06);
      cmp("ret2_empty", 8'(empty), 8'h01);

      // Overflow and underflow
      step("call1", 3'd4, 4'h1);
      step("call2", 3'd4, 4'h2);
      step("callov", 3'd4, 4'h3);
      cmp("callov_err", 8'(err), 8'h01);
      cmp("callov_pc2", 8'(pc_out), 8'h02);
      step("holdov", 3'd0, 4'h0);
      cmp("holdov_err0", 8'(err), 8'h00);
      step("retA", 3'd5, 4'h0);
      step("retB", 3'd5, 4'h0);
      step("retun", 3'd5, 4'h0);
      cmp("retun_err", 8'(err), 8'h01);
      step("holdun", 3'd0, 4'h0);
      cmp("holdun_err0", 8'(err), 8'h00);

      // Reserved code acts as HOLD
      step("rsvd", 3'd7, 4'hA);

      // Call at all-ones PC pushes 0; back-to-back call/return
      step("ldF2", 3'd1, 4'hF);
      step("callF", 3'd4, 4'h4);
      step("retF", 3'd5, 4'h0);
      cmp("retF_pc0", 8'(pc_out), 8'h00);
      step("ld7", 3'd1, 4'h7);
      step("callA", 3'd4, 4'hA);
      step("retA8", 3'd5, 4'h0);
      cmp("retA8_pc8", 8'(pc_out), 8'h08);

      // Reset with entries on the stack leaves it empty
      step("call9", 3'd4, 4'h9);
      do_clr("clr2");
      step("retclr", 3'd5, 4'h0);

      // Counter sweep of {ctrl, pc_in} with random clr pulses
      for (int i = 0; i < 256; i++) begin
         logic [6:0] cnt;
         cnt = 7'(i);
         if ($urandom_range(0, 19) == 0) do_clr("sw_clr");
         step("sweep", cnt[6:4], cnt[3:0]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
